// File: rtl/clock_ctrl_pkg.sv
// Shared op codes, FSM state encoding and request priority for the clock controller.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package clock_ctrl_pkg;

   // Operation codes understood by the counter.
   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_STO0  = 2'b01,
      OP_MADD  = 2'b10,
      OP_RESET = 2'b11
   } op_e;

   // Scheduler FSM states.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ISSUE    = 2'b01,
      ST_WAIT_ACK = 2'b10
   } state_e;

   // Requester bit positions inside the one-hot/pending vectors: {reset,sto0,madd}.
   localparam int NUM_REQ   = 3;
   localparam int REQ_MADD  = 0;
   localparam int REQ_STO0  = 1;
   localparam int REQ_RESET = 2;

   typedef logic [NUM_REQ-1:0] req_vec_t;

   // Fixed priority: reset beats sto0 beats madd. Returns one-hot (or zero).
   function automatic req_vec_t pick_prio(input req_vec_t pend);
      req_vec_t g;
      g = '0;
      if (pend[REQ_RESET])     g[REQ_RESET] = 1'b1;
      else if (pend[REQ_STO0]) g[REQ_STO0]  = 1'b1;
      else if (pend[REQ_MADD]) g[REQ_MADD]  = 1'b1;
      return g;
   endfunction

   // Map a one-hot grant onto the op code sent to the counter.
   function automatic op_e grant_to_op(input req_vec_t g);
      op_e op;
      op = OP_NONE;
      if (g[REQ_RESET])     op = OP_RESET;
      else if (g[REQ_STO0]) op = OP_STO0;
      else if (g[REQ_MADD]) op = OP_MADD;
      return op;
   endfunction

endpackage

// File: rtl/hold_repeat_timer.sv
// Turns a held level into repeat pulses: first pulse on the HOLD_CYCLES-th high sample, then every REPEAT_CYCLES.
// Latency: tick_o is combinational in the cycle whose posedge takes that sample.
// Backpressure: none; dropping the level clears both counters at the next edge.
module hold_repeat_timer #(
   parameter int HOLD_CYCLES   = 5000,
   parameter int REPEAT_CYCLES = 1250
) (
   input  logic clk,
   input  logic rst,
   input  logic level_i,
   output logic tick_o
);
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int RW = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   logic [HW-1:0] hold_q, hold_d;
   logic [RW-1:0] rep_q, rep_d;

   // Hold phase saturates at HOLD_MAX, after which the repeat counter runs modulo the period.
   always_comb begin
      hold_d = hold_q;
      rep_d  = rep_q;
      tick_o = 1'b0;
      if (!level_i) begin
         hold_d = '0;
         rep_d  = '0;
      end else if (hold_q != HOLD_MAX) begin
         hold_d = hold_q + 1'b1;
         tick_o = (hold_q == HOLD_LAST);
      end else if (rep_q == REP_LAST) begin
         rep_d  = '0;
         tick_o = 1'b1;
      end else begin
         rep_d = rep_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         rep_q  <= '0;
      end else begin
         hold_q <= hold_d;
         rep_q  <= rep_d;
      end
   end

endmodule

// File: rtl/op_scheduler.sv
// Arbitrates minute-add / seconds-to-zero / clock-reset requests into single ops for the counter.
// Latency: req rise sampled at E0 -> operation non-zero for the one cycle after E1; grant held until ack/timeout.
// Backpressure: one op in flight; further edges park in per-requester pending bits until IDLE.
module op_scheduler
   import clock_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES   = 5000,
   parameter int REPEAT_CYCLES = 1250,
   parameter int ACK_TIMEOUT   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_madd,
   input  logic       req_sto0,
   input  logic       req_reset,
   input  logic       encoder_reset,
   output logic [1:0] operation,
   output logic [2:0] grant,
   output logic       busy,
   output logic       err_timeout
);
   localparam int WW = $clog2(ACK_TIMEOUT) + 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);

   req_vec_t      req_vec, rise, set_mask, clr_mask;
   req_vec_t      prev_q, seen_low_q;
   req_vec_t      pend_q, pend_d;
   req_vec_t      grant_q, grant_d;
   state_e        state_q, state_d;
   op_e           op_q, op_d;
   logic          err_q, err_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          rep_tick;

   assign req_vec = {req_reset, req_sto0, req_madd};

   // A rise only counts once the input has been seen low since reset, so levels held through reset are ignored.
   assign rise = req_vec & ~prev_q & seen_low_q;

   hold_repeat_timer #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_hold_repeat_timer (
      .clk     (clk),
      .rst     (rst),
      .level_i (req_madd & seen_low_q[REQ_MADD]),
      .tick_o  (rep_tick)
   );

   // Pending-set sources: captured rising edges plus madd auto-repeat ticks.
   always_comb begin
      set_mask           = rise;
      set_mask[REQ_MADD] = rise[REQ_MADD] | rep_tick;
   end

   // Edge history: last sampled level and whether each input has been low since reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= '0;
         seen_low_q <= '0;
      end else begin
         prev_q     <= req_vec;
         seen_low_q <= seen_low_q | ~req_vec;
      end
   end

   // Next state, outputs and pending update; a new edge wins over a same-cycle clear.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      grant_d  = grant_q;
      err_d    = 1'b0;
      wait_d   = wait_q;
      clr_mask = '0;
      case (state_q)
         ST_IDLE: begin
            if (|pend_q) begin
               grant_d = pick_prio(pend_q);
               op_d    = grant_to_op(grant_d);
               // A full clock reset makes outstanding madd/sto0 requests meaningless.
               if (pend_q[REQ_RESET]) begin
                  clr_mask[REQ_MADD] = 1'b1;
                  clr_mask[REQ_STO0] = 1'b1;
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            op_d    = OP_NONE;
            wait_d  = '0;
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (encoder_reset) begin
               clr_mask = grant_q;
               grant_d  = '0;
               state_d  = ST_IDLE;
            end else if (wait_q == WAIT_LAST) begin
               err_d    = 1'b1;
               clr_mask = grant_q;
               grant_d  = '0;
               state_d  = ST_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: begin
            op_d    = OP_NONE;
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
      pend_d = (pend_q & ~clr_mask) | set_mask;
   end

   // FSM and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NONE;
         grant_q <= '0;
         err_q   <= 1'b0;
         wait_q  <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         grant_q <= grant_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
         pend_q  <= pend_d;
      end
   end

   assign operation   = op_q;
   assign grant       = grant_q;
   assign busy        = (state_q != ST_IDLE);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_op_scheduler.sv
// Self-checking bench for op_scheduler: request-level model compared every cycle, plus directed literal checks.
// Inputs change and outputs are sampled on the falling edge; the DUT and the model both act on the rising edge.
module tb_op_scheduler;
   localparam int HOLD = 5000;
   localparam int REP  = 1250;
   localparam int TO   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_madd, req_sto0, req_reset, encoder_reset;
   logic [1:0] operation;
   logic [2:0] grant;
   logic       busy, err_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   op_scheduler #(
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REP),
      .ACK_TIMEOUT   (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_madd      (req_madd),
      .req_sto0      (req_sto0),
      .req_reset     (req_reset),
      .encoder_reset (encoder_reset),
      .operation     (operation),
      .grant         (grant),
      .busy          (busy),
      .err_timeout   (err_timeout)
   );

   // ---------------- request-level reference model ----------------
   // pending set per requester, one op in flight with an age counter,
   // and madd auto-repeat derived from the length of the current high run.
   logic [2:0] m_pend     = '0;
   logic [2:0] m_prev_low = '0;
   logic [2:0] m_grant    = '0;
   logic [1:0] m_op       = '0;
   bit         m_active   = 0;
   bit         m_err      = 0;
   int         m_age      = 0;
   int         m_run      = 0;

   always @(posedge clk) begin
      logic [2:0] inp, rise, setm, clrm;
      bit fire;
      inp = {req_reset, req_sto0, req_madd};
      if (rst) begin
         m_pend = '0; m_prev_low = '0; m_grant = '0; m_op = '0;
         m_active = 0; m_err = 0; m_age = 0; m_run = 0;
      end else begin
         rise = inp & m_prev_low;
         m_prev_low = ~inp;
         if (rise[0])                 m_run = 1;
         else if (inp[0] && m_run > 0) m_run = m_run + 1;
         else                         m_run = 0;
         fire = (m_run == HOLD) || (m_run > HOLD && ((m_run - HOLD) % REP) == 0);
         setm = rise | {2'b00, fire};
         clrm = '0;
         m_err = 0;
         if (!m_active) begin
            if (m_pend != 0) begin
               if (m_pend[2])      begin m_grant = 3'b100; m_op = 2'b11; clrm = 3'b011; end
               else if (m_pend[1]) begin m_grant = 3'b010; m_op = 2'b01; end
               else                begin m_grant = 3'b001; m_op = 2'b10; end
               m_active = 1;
               m_age    = 0;
            end
         end else if (m_age == 0) begin
            m_op  = 2'b00;
            m_age = 1;
         end else if (encoder_reset || m_age == TO) begin
            m_err    = !encoder_reset;
            clrm     = clrm | m_grant;
            m_grant  = '0;
            m_active = 0;
         end else begin
            m_age = m_age + 1;
         end
         m_pend = (m_pend & ~clrm) | setm;
      end
   end

   // ---------------- bookkeeping ----------------
   int cyc = 0;
   int n_op[4];
   int n_g[8];
   int n_busy = 0, n_err = 0, mn_madd = 0;
   int last_op_cyc[4];
   int last_err_cyc = 0;
   int madd_first = -1, madd_last = -1;
   int b_op[4];
   int b_g[8];
   int b_busy, b_err, b_mn;
   bit ack_en = 0, force_ack = 0;
   int ack_pend = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   task automatic snap();
      for (int i = 0; i < 4; i++) b_op[i] = n_op[i];
      for (int i = 0; i < 8; i++) b_g[i] = n_g[i];
      b_busy = n_busy; b_err = n_err; b_mn = mn_madd;
   endtask

   // Each falling edge: compare against the model, tally activity, then run the ack responder
   // (ack is raised for one cycle, one idle cycle after the op cycle).
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cyc++;
         check("cycle_outputs", {25'd0, operation, grant, busy, err_timeout},
                                {25'd0, m_op, m_grant, m_active, m_err});
         n_op[operation]++;
         n_g[grant]++;
         if (busy) n_busy++;
         if (err_timeout) begin n_err++; last_err_cyc = cyc; end
         if (operation != 2'b00) last_op_cyc[operation] = cyc;
         if (operation == 2'b10) begin
            if (madd_first < 0) madd_first = cyc;
            madd_last = cyc;
         end
         if (m_op == 2'b10) mn_madd++;
         encoder_reset = force_ack;
         if (ack_pend == 1) encoder_reset = 1'b1;
         if (ack_pend > 0) ack_pend--;
         if (ack_en && operation != 2'b00) ack_pend = 2;
      end
   endtask

   initial begin
      rst = 1'b1; req_madd = 1'b0; req_sto0 = 1'b0; req_reset = 1'b0; encoder_reset = 1'b0;
      tick(3);
      check("reset_outputs", {25'd0, operation, grant, busy, err_timeout}, 32'd0);
      rst = 1'b0;
      tick(2);

      // single madd pulse, acked one cycle after the op cycle
      ack_en = 1; snap();
      req_madd = 1'b1; tick(1); req_madd = 1'b0; tick(12);
      check("A_madd_ops",   n_op[2] - b_op[2], 1);
      check("A_busy_cycles", n_busy - b_busy,  3);
      check("A_grant_001",  n_g[1] - b_g[1],   3);
      check("A_no_err",     n_err - b_err,     0);

      // all three rise together: only the clock reset is issued
      snap();
      req_madd = 1'b1; req_sto0 = 1'b1; req_reset = 1'b1; tick(1);
      req_madd = 1'b0; req_sto0 = 1'b0; req_reset = 1'b0; tick(15);
      check("B_reset_ops", n_op[3] - b_op[3], 1);
      check("B_sto0_ops",  n_op[1] - b_op[1], 0);
      check("B_madd_ops",  n_op[2] - b_op[2], 0);
      check("B_grant_100", n_g[4] - b_g[4],   3);

      // sto0 edge while madd waits for its ack
      snap();
      req_madd = 1'b1; tick(1); req_madd = 1'b0; tick(2);
      req_sto0 = 1'b1; tick(1); req_sto0 = 1'b0; tick(15);
      check("C_madd_ops",  n_op[2] - b_op[2], 1);
      check("C_sto0_ops",  n_op[1] - b_op[1], 1);
      check("C_sto0_gap",  last_op_cyc[1] - last_op_cyc[2], 4);
      check("C_busy",      n_busy - b_busy, 6);

      // no ack: timeout pulse and pending dropped
      ack_en = 0; snap();
      req_madd = 1'b1; tick(1); req_madd = 1'b0; tick(20);
      check("D_madd_ops",   n_op[2] - b_op[2], 1);
      check("D_err_pulses", n_err - b_err, 1);
      check("D_err_delay",  last_err_cyc - last_op_cyc[2], TO + 1);
      check("D_busy",       n_busy - b_busy, TO + 1);

      // ack while idle is ignored
      ack_en = 1; snap();
      force_ack = 1; tick(3); force_ack = 0; tick(3);
      check("G_idle_ack_busy", n_busy - b_busy, 0);

      // held madd: edge, hold, two repeats
      snap(); madd_first = -1; madd_last = -1;
      req_madd = 1'b1; tick(HOLD + 2 * REP); req_madd = 1'b0; tick(3000);
      check("E_madd_ops",       n_op[2] - b_op[2], 4);
      check("E_model_madd_ops", mn_madd - b_mn, 4);
      check("E_first_to_last",  madd_last - madd_first, 7499);

      // reset during WAIT_ACK with req_reset held high
      ack_en = 0;
      req_reset = 1'b1; tick(3);
      snap();
      rst = 1'b1; tick(1); rst = 1'b0;
      check("F_reset_outputs", {25'd0, operation, grant, busy, err_timeout}, 32'd0);
      tick(10);
      check("F_no_op_held",  n_op[3] - b_op[3], 0);
      check("F_no_err",      n_err - b_err, 0);
      req_reset = 1'b0; tick(2);
      ack_en = 1;
      req_reset = 1'b1; tick(1); req_reset = 1'b0; tick(10);
      check("F_op_after_new_edge", n_op[3] - b_op[3], 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
